vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Generates 640x480@60 Hz VGA raster timing on the 25.175 MHz pixel clock produced by the PLL.
//  Outputs: hsync/vsync, active-video flag, pixel coordinates, line/frame strobes.
//  Sits directly downstream of the PLL; feeds the pixel/colour generator and the VGA pins.
// PARAMETERS
//  H_ACTIVE   640  visible pixels per line
//  H_FP       16   horizontal front porch (clocks)
//  H_SYNC     96   hsync pulse width (clocks)
//  H_BP       48   horizontal back porch (clocks)
//  V_ACTIVE   480  visible lines per frame
//  V_FP       10   vertical front porch (lines)
//  V_SYNC     2    vsync pulse width (lines)
//  V_BP       33   vertical back porch (lines)
//  HSYNC_POL  0    asserted level of hsync_o (0 = active-low)
//  VSYNC_POL  0    asserted level of vsync_o (0 = active-low)
//  CNT_W      10   width of counters and x_o/y_o; must hold H_TOTAL-1 and V_TOTAL-1
// PORTS
//  clk_i          in   1      pixel clock (PLL global output, 25.175 MHz)
//  rst_n_i        in   1      asynchronous active-low reset
//  en_i           in   1      count enable; low = freeze raster
//  hsync_o        out  1      horizontal sync, polarity per HSYNC_POL
//  vsync_o        out  1      vertical sync, polarity per VSYNC_POL
//  active_o       out  1      1 while (x_o,y_o) is inside the visible area
//  x_o            out  CNT_W  horizontal count, 0..H_TOTAL-1
//  y_o            out  CNT_W  vertical count, 0..V_TOTAL-1
//  line_start_o   out  1      1-cycle pulse when x_o==0
//  frame_start_o  out  1      1-cycle pulse when x_o==0 && y_o==0
// BEHAVIOUR
//  - Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
//  - Internal counters h_cnt, v_cnt. On each clk_i edge with en_i=1:
//    - h_cnt increments and wraps H_TOTAL-1 -> 0.
//    - v_cnt increments only when h_cnt wraps; v_cnt wraps V_TOTAL-1 -> 0 at that same edge.
//  - en_i=0: counters and all outputs hold their values; strobes hold too (no re-pulse on resume).
//  - All outputs are registered and decoded from the counter values. Latency: exactly 1 cycle
//    from counter to output, with all outputs mutually aligned.
//  - active_o = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
//  - hsync asserted iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
//  - vsync asserted iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491), for whole lines.
//  - x_o = h_cnt, y_o = v_cnt (registered); the consumer gates its pixel data with active_o.
//  - Reset (rst_n_i low, asynchronous, any point in the frame), immediately:
//    - h_cnt = v_cnt = 0; x_o = y_o = 0.
//    - hsync_o = ~HSYNC_POL; vsync_o = ~VSYNC_POL.
//    - active_o = 0; line_start_o = 0; frame_start_o = 0.
//  - First enabled edge after reset release: outputs show (0,0).
//    - active_o = 1, line_start_o = 1, frame_start_o = 1.
//    - h_cnt advances to 1 on that same edge.
//  - Wrap edge case: at h_cnt = H_TOTAL-1 with v_cnt = V_TOTAL-1, both counters go to 0 on the same edge.
//  - No illegal states: counter values >= total cannot occur. Defensively, such a value goes to 0 on the next edge.
// TESTING
//  1. Assert rst_n_i mid-frame (x=300, y=200) -> all outputs take reset values with no clock edge.
//     Hold en_i=1; first edge after release -> x_o=0, y_o=0, frame_start_o=1, active_o=1.
//  2. Default params, en_i=1:
//     - frame_start_o period = 420000 clocks.
//     - line_start_o period = 800 clocks.
//     - active_o high 640 of every 800 clocks on lines 0..479, and 0 on lines 480..524.
//  3. Default params:
//     - hsync_o low for exactly 96 clocks, falling 656 clocks after each line_start_o.
//     - vsync_o low for exactly 1600 clocks, falling 392000 clocks after frame_start_o.
//  4. en_i=0 for 50 clocks at x=639, y=479 -> outputs frozen.
//     On resume, next x_o=640 and active_o=0; frame period is stretched by exactly 50 clocks.
//  5. Params: H 8/1/2/1, V 4/1/1/1, HSYNC_POL=1 -> frame period 84 clocks.
//     hsync_o high at x=9..10; vsync_o high on y=5; x_o wraps 11->0 and y_o wraps 6->0.
//  6. Random en_i toggling over 3 frames -> scoreboard model matches x_o/y_o/syncs every cycle.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running h/v counters with registered
// sync, active-video, coordinate and line/frame strobe outputs.
module vga_timing_gen #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   CNT_W     = 10
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             active_o,
  output logic [CNT_W-1:0] x_o,
  output logic [CNT_W-1:0] y_o,
  output logic             line_start_o,
  output logic             frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic [CNT_W-1:0] h_nxt, v_nxt;
  logic             h_wrap;
  logic             hs_act, vs_act, vis;

  // Out-of-range counts (never expected) fall back to zero on the next edge.
  always_comb begin
    h_wrap = (h_cnt >= H_LAST);
    h_nxt  = h_wrap ? '0 : h_cnt + CNT_W'(1);
    v_nxt  = v_cnt;
    if (v_cnt > V_LAST) begin
      v_nxt = '0;
    end else if (h_wrap) begin
      v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    hs_act = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
    vs_act = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
    vis    = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
  end

  // Outputs decode the pre-increment counter value, so they trail the counters by one edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      h_cnt         <= '0;
      v_cnt         <= '0;
      x_o           <= '0;
      y_o           <= '0;
      hsync_o       <= ~HSYNC_POL;
      vsync_o       <= ~VSYNC_POL;
      active_o      <= 1'b0;
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
    end else if (en_i) begin
      h_cnt         <= h_nxt;
      v_cnt         <= v_nxt;
      x_o           <= h_cnt;
      y_o           <= v_cnt;
      hsync_o       <= hs_act ? HSYNC_POL : ~HSYNC_POL;
      vsync_o       <= vs_act ? VSYNC_POL : ~VSYNC_POL;
      active_o      <= vis;
      line_start_o  <= (h_cnt == '0);
      frame_start_o <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a tiny 12x7 instance,
// both checked every cycle against a position-from-edge-count model.
module tb_vga_timing_gen;

  logic       clk;
  logic       rst_n;
  logic       en_d, en_s;
  logic       hsync_d, vsync_d, active_d, line_d, frame_d;
  logic [9:0] x_d, y_d;
  logic       hsync_s, vsync_s, active_s, line_s, frame_s;
  logic [9:0] x_s, y_s;

  int checks   = 0;
  int failures = 0;

  longint n_d, n_s;

  vga_timing_gen u_dut_d (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en_d),
    .hsync_o(hsync_d), .vsync_o(vsync_d), .active_o(active_d),
    .x_o(x_d), .y_o(y_d), .line_start_o(line_d), .frame_start_o(frame_d)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CNT_W(10)
  ) u_dut_s (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en_s),
    .hsync_o(hsync_s), .vsync_o(vsync_s), .active_o(active_s),
    .x_o(x_s), .y_o(y_s), .line_start_o(line_s), .frame_start_o(frame_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // n = enabled edges since reset; output after edge n shows raster position n-1.
  function automatic logic [24:0] model_out(longint n, int ha, int hf, int hs, int hb,
                                            int va, int vf, int vs, int vb, bit hp, bit vp);
    int     ht, vt, x, y;
    longint p;
    logic   hsa, vsa;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    if (n == 0) return {~hp, ~vp, 3'b000, 20'd0};
    p   = (n - 1) % longint'(ht * vt);
    x   = int'(p % ht);
    y   = int'(p / ht);
    hsa = (x >= ha + hf) && (x < ha + hf + hs);
    vsa = (y >= va + vf) && (y < va + vf + vs);
    return {hsa ? hp : ~hp, vsa ? vp : ~vp, (x < ha) && (y < va),
            x == 0, (x == 0) && (y == 0), 10'(x), 10'(y)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_d <= 0;
      n_s <= 0;
    end else begin
      if (en_d) n_d <= n_d + 1;
      if (en_s) n_s <= n_s + 1;
    end
  end

  always @(negedge clk) begin
    logic [24:0] exp_d, exp_s, got_d, got_s;
    exp_d = model_out(n_d, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
    exp_s = model_out(n_s, 8, 1, 2, 1, 4, 1, 1, 1, 1'b1, 1'b1);
    got_d = {hsync_d, vsync_d, active_d, line_d, frame_d, x_d, y_d};
    got_s = {hsync_s, vsync_s, active_s, line_s, frame_s, x_s, y_s};
    checks++;
    if (got_d !== exp_d) begin
      failures++;
      $display("FAIL model_d @%0t: got %h expected %h", $time, got_d, exp_d);
    end
    checks++;
    if (got_s !== exp_s) begin
      failures++;
      $display("FAIL model_s @%0t: got %h expected %h", $time, got_s, exp_s);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_x_d"},  int'(x_d), 0);
    check({tag, "_y_d"},  int'(y_d), 0);
    check({tag, "_hs_d"}, int'(hsync_d), 1);
    check({tag, "_vs_d"}, int'(vsync_d), 1);
    check({tag, "_act_d"}, int'(active_d), 0);
    check({tag, "_ls_d"}, int'(line_d), 0);
    check({tag, "_fs_d"}, int'(frame_d), 0);
    check({tag, "_x_s"},  int'(x_s), 0);
    check({tag, "_hs_s"}, int'(hsync_s), 0);
    check({tag, "_vs_s"}, int'(vsync_s), 0);
    check({tag, "_fs_s"}, int'(frame_s), 0);
  endtask

  task automatic check_origin(input string tag);
    check({tag, "_x_d"},  int'(x_d), 0);
    check({tag, "_y_d"},  int'(y_d), 0);
    check({tag, "_fs_d"}, int'(frame_d), 1);
    check({tag, "_ls_d"}, int'(line_d), 1);
    check({tag, "_act_d"}, int'(active_d), 1);
    check({tag, "_fs_s"}, int'(frame_s), 1);
    check({tag, "_act_s"}, int'(active_s), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, act_cnt, hs_cnt, hs_fall, vs_cnt, ln_cnt;
    int hs_min, hs_max, vy_min, vy_max, xmax, ymax;

    rst_n = 1'b0;
    en_d  = 1'b1;
    en_s  = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_origin("first_edge");

    // One full line of the default raster, starting from the (0,0) sample.
    k = 0; act_cnt = 0; hs_cnt = 0; hs_fall = -1;
    do begin
      if (active_d) act_cnt++;
      if (!hsync_d) begin
        hs_cnt++;
        if (hs_fall < 0) hs_fall = k;
      end
      @(negedge clk);
      k++;
    end while (!line_d && k < 2000);
    check("line_period_d", k, 800);
    check("line_active_d", act_cnt, 640);
    check("hsync_width_d", hs_cnt, 96);
    check("hsync_fall_d", hs_fall, 656);
    check("line1_y_d", int'(y_d), 1);

    // One full frame of the small raster.
    k = 0;
    while (!frame_s && k < 200) begin @(negedge clk); k++; end
    check("frame_s_found", int'(frame_s), 1);
    k = 0; act_cnt = 0; hs_cnt = 0; vs_cnt = 0; ln_cnt = 0;
    hs_min = 99; hs_max = -1; vy_min = 99; vy_max = -1; xmax = 0; ymax = 0;
    do begin
      if (hsync_s) begin
        hs_cnt++;
        if (int'(x_s) < hs_min) hs_min = int'(x_s);
        if (int'(x_s) > hs_max) hs_max = int'(x_s);
      end
      if (vsync_s) begin
        vs_cnt++;
        if (int'(y_s) < vy_min) vy_min = int'(y_s);
        if (int'(y_s) > vy_max) vy_max = int'(y_s);
      end
      if (active_s) act_cnt++;
      if (line_s) ln_cnt++;
      if (int'(x_s) > xmax) xmax = int'(x_s);
      if (int'(y_s) > ymax) ymax = int'(y_s);
      @(negedge clk);
      k++;
    end while (!frame_s && k < 200);
    check("frame_period_s", k, 84);
    check("hsync_cnt_s", hs_cnt, 14);
    check("hsync_xmin_s", hs_min, 9);
    check("hsync_xmax_s", hs_max, 10);
    check("vsync_cnt_s", vs_cnt, 12);
    check("vsync_ymin_s", vy_min, 5);
    check("vsync_ymax_s", vy_max, 5);
    check("active_cnt_s", act_cnt, 32);
    check("line_cnt_s", ln_cnt, 7);
    check("xmax_s", xmax, 11);
    check("ymax_s", ymax, 6);

    // Freeze at the last visible pixel for 50 clocks; frame stretches by 50.
    k = 0;
    while (!(x_s == 10'd7 && y_s == 10'd3) && k < 200) begin @(negedge clk); k++; end
    #1 en_s = 1'b0;
    repeat (50) begin @(negedge clk); k++; end
    check("stall_x_s", int'(x_s), 7);
    check("stall_y_s", int'(y_s), 3);
    check("stall_act_s", int'(active_s), 1);
    #1 en_s = 1'b1;
    @(negedge clk); k++;
    check("resume_x_s", int'(x_s), 8);
    check("resume_act_s", int'(active_s), 0);
    while (!frame_s && k < 400) begin @(negedge clk); k++; end
    check("stretched_period_s", k, 134);

    // Asynchronous reset mid-line: outputs clear with no clock edge.
    k = 0;
    while (x_d != 10'd300 && k < 1000) begin @(negedge clk); k++; end
    check("reach_x300_d", int'(x_d), 300);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async");
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_origin("after_async");

    // Random enable toggling on both instances; the per-cycle model covers it.
    repeat (504) begin
      @(negedge clk);
      #1;
      en_s = 1'($urandom_range(0, 1));
      en_d = 1'($urandom_range(0, 1));
    end
    #1 en_s = 1'b1;
    en_d = 1'b1;
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
